// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer timing and control slice.
package mano_pkg;

    // Sequence counter width; the downstream 4x16 timing decoder needs 4.
    localparam int SC_WIDTH  = 4;
    // SC value at which the interrupt cycle finishes (RT2).
    localparam int INT_END_T = 2;

    // IR bit positions that control logic decodes into strobes:
    // HLT = 7001 (B0), ION = F080 (B7), IOF = F040 (B6).
    localparam int HLT_BIT = 0;
    localparam int ION_BIT = 7;
    localparam int IOF_BIT = 6;

    // True while SC is still inside the fetch/decode or interrupt-entry
    // window (T0..T<end_t>), where an interrupt must not be recognised.
    function automatic logic in_entry_window(input int unsigned t,
                                             input int unsigned end_t);
        return (t <= end_t);
    endfunction

endpackage

// File: rtl/mano_sc_counter.sv
// Sequence counter with hold, synchronous clear and increment, plus a
// one-cycle wrap indication when an increment rolls the count over.
module mano_sc_counter
#(
    parameter int WIDTH = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inr,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] count_inc;

    assign carry[0] = inr;

    // Ripple-carry incrementer; carry[WIDTH] marks an all-ones rollover.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_inc
            assign count_inc[gi]  = count_reg[gi] ^ carry[gi];
            assign carry[gi + 1]  = carry[gi] & count_reg[gi];
        end
    endgenerate

    // Next count: hold beats clear, clear beats increment.
    always_comb begin
        count_next = count_reg;
        if (hold) begin
            count_next = count_reg;
        end else if (clr) begin
            count_next = '0;
        end else begin
            count_next = count_inc;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign wrap  = carry[WIDTH] & ~hold & ~clr;

endmodule

// File: rtl/mano_seq_timing.sv
// Timing-control stage of the Mano basic computer: sequence counter SC,
// start/stop flip-flop S, interrupt enable IEN and interrupt flip-flop R.
module mano_seq_timing
#(
    parameter int SC_WIDTH  = mano_pkg::SC_WIDTH,
    parameter int INT_END_T = mano_pkg::INT_END_T
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                hlt,
    input  logic                sc_clr,
    input  logic                ion,
    input  logic                iof,
    input  logic                fgi,
    input  logic                fgo,
    output logic [SC_WIDTH-1:0] sc,
    output logic                s_flag,
    output logic                ien,
    output logic                r_flag,
    output logic                sc_ovf
);

    import mano_pkg::*;

    localparam logic [SC_WIDTH-1:0] END_T = SC_WIDTH'(INT_END_T);

    logic s_reg,   s_next;
    logic ien_reg, ien_next;
    logic r_reg,   r_next;
    logic ovf_reg, ovf_next;

    logic [SC_WIDTH-1:0] sc_count;
    logic                sc_wrap;
    logic                sc_hold;
    logic                sc_clear;
    logic                rt2_done;
    logic                r_set;

    // RT2: the interrupt cycle ends and returns SC to T0.
    assign rt2_done = s_reg & r_reg & (sc_count == END_T);

    // Interrupt recognised at the end of an execute-phase timing step.
    assign r_set = s_reg & ~r_reg & ien_reg & (fgi | fgo) &
                   ~in_entry_window(int'(sc_count), INT_END_T);

    // A stopped machine freezes SC; it is already 0 after a halt or reset.
    assign sc_hold  = ~s_reg;
    assign sc_clear = hlt | sc_clr | rt2_done;

    mano_sc_counter #(
        .WIDTH (SC_WIDTH)
    ) u_sc_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sc_clear),
        .inr   (1'b1),
        .hold  (sc_hold),
        .count (sc_count),
        .wrap  (sc_wrap)
    );

    // Flip-flop next-state logic: halt beats start, RT2 beats ION, IOF beats ION.
    always_comb begin
        s_next   = s_reg;
        ien_next = ien_reg;
        r_next   = r_reg;
        ovf_next = ovf_reg;

        if (!s_reg) begin
            s_next = start & ~hlt;
        end else if (hlt) begin
            s_next = 1'b0;
        end

        if (rt2_done) begin
            r_next = 1'b0;
        end else if (r_set) begin
            r_next = 1'b1;
        end

        if (rt2_done) begin
            ien_next = 1'b0;
        end else if (iof) begin
            ien_next = 1'b0;
        end else if (ion) begin
            ien_next = 1'b1;
        end

        if (sc_wrap) begin
            ovf_next = 1'b1;
        end
    end

    // State registers for S, IEN, R and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg   <= 1'b0;
            ien_reg <= 1'b0;
            r_reg   <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            s_reg   <= s_next;
            ien_reg <= ien_next;
            r_reg   <= r_next;
            ovf_reg <= ovf_next;
        end
    end

    assign sc     = sc_count;
    assign s_flag = s_reg;
    assign ien    = ien_reg;
    assign r_flag = r_reg;
    assign sc_ovf = ovf_reg;

endmodule

// File: tb/tb_mano_seq_timing.sv
// Self-checking bench for mano_seq_timing: directed walk through the timing
// scenarios followed by randomized strobes, all compared against a
// behavioural model of the timing rules.
module tb_mano_seq_timing;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       hlt    = 1'b0;
    logic       sc_clr = 1'b0;
    logic       ion    = 1'b0;
    logic       iof    = 1'b0;
    logic       fgi    = 1'b0;
    logic       fgo    = 1'b0;
    logic [3:0] sc;
    logic       s_flag;
    logic       ien;
    logic       r_flag;
    logic       sc_ovf;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    mano_seq_timing #(
        .SC_WIDTH  (4),
        .INT_END_T (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .hlt    (hlt),
        .sc_clr (sc_clr),
        .ion    (ion),
        .iof    (iof),
        .fgi    (fgi),
        .fgo    (fgo),
        .sc     (sc),
        .s_flag (s_flag),
        .ien    (ien),
        .r_flag (r_flag),
        .sc_ovf (sc_ovf)
    );

    // Behavioural model of the machine state, one step per rising edge.
    int m_sc  = 0;
    bit m_s   = 1'b0;
    bit m_ien = 1'b0;
    bit m_r   = 1'b0;
    bit m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int nsc;
        bit ns, nien, nr, novf, rt2, rset;
        if (!rst_n) begin
            m_sc  <= 0;
            m_s   <= 1'b0;
            m_ien <= 1'b0;
            m_r   <= 1'b0;
            m_ovf <= 1'b0;
        end else begin
            nsc  = m_sc;
            ns   = m_s;
            nien = m_ien;
            nr   = m_r;
            novf = m_ovf;
            rt2  = m_s && m_r && (m_sc == 2);
            rset = m_s && !m_r && (m_sc > 2) && m_ien && (fgi || fgo);
            if (!m_s) begin
                if (start && !hlt) ns = 1'b1;
            end else begin
                if (hlt) begin
                    ns  = 1'b0;
                    nsc = 0;
                end else if (sc_clr || rt2) begin
                    nsc = 0;
                end else begin
                    nsc = (m_sc + 1) % 16;
                    if (nsc == 0) novf = 1'b1;
                end
                if (rt2)  nr = 1'b0;
                if (rset) nr = 1'b1;
            end
            if (rt2)      nien = 1'b0;
            else if (iof) nien = 1'b0;
            else if (ion) nien = 1'b1;
            m_sc  <= nsc;
            m_s   <= ns;
            m_ien <= nien;
            m_r   <= nr;
            m_ovf <= novf;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks = checks + 1;
            if (sc !== 4'(m_sc) || s_flag !== m_s || ien !== m_ien ||
                r_flag !== m_r || sc_ovf !== m_ovf) begin
                failures = failures + 1;
                $display("FAIL model_cmp t=%0t got sc=%0d s=%0b ien=%0b r=%0b ovf=%0b exp sc=%0d s=%0b ien=%0b r=%0b ovf=%0b",
                         $time, sc, s_flag, ien, r_flag, sc_ovf,
                         m_sc, m_s, m_ien, m_r, m_ovf);
            end
        end
    end

    // Literal expectation for a directed step; one line per transaction.
    task automatic expect_out(input string name, input int esc, input bit es,
                              input bit eien, input bit er, input bit eovf);
        checks = checks + 1;
        if (sc !== 4'(esc) || s_flag !== es || ien !== eien ||
            r_flag !== er || sc_ovf !== eovf) begin
            failures = failures + 1;
            $display("FAIL %s got sc=%0d s=%0b ien=%0b r=%0b ovf=%0b exp sc=%0d s=%0b ien=%0b r=%0b ovf=%0b",
                     name, sc, s_flag, ien, r_flag, sc_ovf, esc, es, eien, er, eovf);
        end else begin
            $display("step %s ok sc=%0d s=%0b ien=%0b r=%0b ovf=%0b",
                     name, sc, s_flag, ien, r_flag, sc_ovf);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cmp_en = 1'b1;

        // 1. Reset then start
        tick(3);
        expect_out("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        expect_out("start_t0", 0, 1, 0, 0, 0);
        tick(1); expect_out("t1", 1, 1, 0, 0, 0);
        tick(1); expect_out("t2", 2, 1, 0, 0, 0);
        tick(1); expect_out("t3", 3, 1, 0, 0, 0);

        // 2. Instruction end
        tick(2); expect_out("t5", 5, 1, 0, 0, 0);
        sc_clr = 1'b1;
        tick(1);
        sc_clr = 1'b0;
        expect_out("sc_clr", 0, 1, 0, 0, 0);
        tick(1); expect_out("after_clr", 1, 1, 0, 0, 0);

        // 3. Interrupt entry and exit
        ion = 1'b1;
        tick(1);
        ion = 1'b0;
        expect_out("ion", 2, 1, 1, 0, 0);
        tick(2); expect_out("int_t4", 4, 1, 1, 0, 0);
        fgi = 1'b1;
        tick(1);
        fgi = 1'b0;
        expect_out("r_set", 5, 1, 1, 1, 0);
        sc_clr = 1'b1;
        tick(1);
        sc_clr = 1'b0;
        expect_out("rt0", 0, 1, 1, 1, 0);
        tick(1); expect_out("rt1", 1, 1, 1, 1, 0);
        tick(1); expect_out("rt2", 2, 1, 1, 1, 0);
        tick(1); expect_out("rt2_done", 0, 1, 0, 0, 0);
        ion = 1'b1;
        fgi = 1'b1;
        tick(1);
        ion = 1'b0;
        expect_out("no_r_t0", 1, 1, 1, 0, 0);
        tick(1); expect_out("no_r_t1", 2, 1, 1, 0, 0);
        tick(1); expect_out("no_r_t2", 3, 1, 1, 0, 0);
        tick(1); expect_out("r_at_t3", 4, 1, 1, 1, 0);
        fgi = 1'b0;
        sc_clr = 1'b1;
        tick(1);
        sc_clr = 1'b0;
        tick(3); expect_out("rt2_done2", 0, 1, 0, 0, 0);

        // 4. Halt precedence
        tick(3); expect_out("pre_hlt", 3, 1, 0, 0, 0);
        start = 1'b1;
        hlt   = 1'b1;
        tick(1);
        start = 1'b0;
        hlt   = 1'b0;
        expect_out("hlt", 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            expect_out("halted", 0, 0, 0, 0, 0);
        end

        // 5. Overflow
        start = 1'b1;
        tick(1);
        start = 1'b0;
        expect_out("restart", 0, 1, 0, 0, 0);
        tick(15); expect_out("t15", 15, 1, 0, 0, 0);
        tick(1);  expect_out("wrap", 0, 1, 0, 0, 1);
        tick(3);  expect_out("ovf_sticky", 3, 1, 0, 0, 1);

        // 6. Async reset mid-operation
        ion = 1'b1;
        tick(1);
        ion = 1'b0;
        expect_out("ion2", 4, 1, 1, 0, 1);
        fgo = 1'b1;
        tick(1);
        fgo = 1'b0;
        expect_out("r_set2", 5, 1, 1, 1, 1);
        tick(2); expect_out("sc7_r", 7, 1, 1, 1, 1);
        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized strobes checked every cycle by the model compare.
        for (int i = 0; i < 2000; i++) begin
            start  = ($urandom_range(0, 7) == 0);
            hlt    = ($urandom_range(0, 39) == 0);
            sc_clr = m_s && (m_sc >= 3) && ($urandom_range(0, 4) == 0);
            ion    = ($urandom_range(0, 9) == 0);
            iof    = ($urandom_range(0, 9) == 0);
            fgi    = ($urandom_range(0, 4) == 0);
            fgo    = ($urandom_range(0, 4) == 0);
            tick(1);
            if (i % 500 == 499) begin
                #2 rst_n = 1'b0;
                #1 expect_out("rand_async_rst", 0, 0, 0, 0, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mano_seq_timing.md
Name: mano_seq_timing

Overview:
- Timing-control stage of the Mano basic computer.
- Holds the 4-bit sequence counter SC, the start/stop flip-flop S, the interrupt-enable flip-flop IEN and the interrupt flip-flop R.
- Output sc drives the 4x16 timing decoder directly, which produces T0..T15.
- Control logic feeds back clear/halt strobes that are decoded from D0..D7 and T0..T15.

Parameters:
- SC_WIDTH, 4, sequence counter width; the decoder downstream requires 4.
- INT_END_T, 2, SC value at which the interrupt cycle completes (the RT2 step).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  sets S (run) when S=0.
- hlt  in  1  HLT strobe from control logic (D7·I'·T3·B0); stops the machine.
- sc_clr  in  1  end-of-instruction SC clear from control logic.
- ion  in  1  ION strobe; sets IEN.
- iof  in  1  IOF strobe; clears IEN.
- fgi  in  1  input flag (level).
- fgo  in  1  output flag (level).
- sc  out  SC_WIDTH  current sequence count; feeds the 4x16 decoder.
- s_flag  out  1  S flip-flop (1 = running).
- ien  out  1  IEN flip-flop.
- r_flag  out  1  R flip-flop (1 = interrupt cycle in progress).
- sc_ovf  out  1  sticky flag, set when SC wraps 15->0 without a clear.

Behaviour:
- Reset
  - Asynchronous active-low on rst_n, independent of clk.
  - While rst_n=0: sc=0, s_flag=0, ien=0, r_flag=0, sc_ovf=0.
  - Deassertion mid-instruction restarts with S=0; there is no resumption.
- All outputs are registered, with no combinational path from input to output. Each strobe takes effect on the next rising edge (latency 1).
- S flip-flop
  - start with S=0: S<=1 and sc stays 0. T0 is visible in the first cycle after the edge, and counting begins on the following edge.
  - start with S=1: ignored.
  - hlt: S<=0 and sc<=0 on the same edge.
  - start and hlt together: hlt wins.
- SC next-state, highest priority first:
  1. S=0 and no start: hold. Strobes other than start, ion and iof are ignored.
  2. hlt: sc<=0.
  3. sc_clr, or R=1 with sc==INT_END_T: sc<=0.
  4. Otherwise: sc<=sc+1, modulo 2^SC_WIDTH. On a 15->0 wrap, also set sc_ovf. sc_ovf clears only on reset.
- R set
  - Condition on an edge: S=1, R=0, sc not in {0,1,2}, ien=1, and (fgi|fgo)=1.
  - Sampled every running cycle, so setting R in the same cycle as sc_clr is legal; the new instruction then begins as an interrupt cycle.
- R clear: on the edge where R=1 and sc==INT_END_T, R<=0, IEN<=0 and sc<=0, all together.
- IEN
  - ion sets it; iof clears it.
  - ion and iof together: iof wins.
  - The RT2 clear overrides ion.
  - ion/iof are honoured even when S=0.
- fgi/fgo are levels; this block never clears them.
- While R=1, sc_clr is still honoured, but control logic must not assert it before RT2.

Decomposition:
- Shared package mano_pkg holds:
  - SC_WIDTH and INT_END_T constants.
  - Opcode localparams HLT_BIT, ION_BIT and IOF_BIT, used by control logic to form the strobes.
- One sub-module is natural: mano_sc_counter, a SC_WIDTH-bit counter.
  - Inputs: clr, inr, hold.
  - Outputs: count and a wrap pulse.
- S/R/IEN flip-flops and the priority logic live in the top.

Test Plan:
1. Reset then start
   - Stimulus: rst_n low 3 cycles, release, pulse start 1 cycle.
   - Response: all outputs 0 after reset; s_flag=1 after the start edge; sc sequence 0,1,2,3... on later edges.
2. Instruction end
   - Stimulus: running, assert sc_clr when sc=5.
   - Response: next sc=0, then 1; s_flag stays 1.
3. Interrupt entry and exit
   - Stimulus: ion pulse, fgi=1 while sc=4.
   - Response: r_flag=1 next edge.
   - Then: sc_clr at sc=5 gives sc=0; sc runs 1,2; at sc=2 the edge gives r_flag=0, ien=0, sc=0.
   - Check: r_flag does not set while sc∈{0,1,2}.
4. Halt precedence
   - Stimulus: start and hlt together while running at sc=3.
   - Response: s_flag=0, sc=0, and sc holds 0 for 10 cycles.
5. Overflow
   - Stimulus: run 16 edges with no sc_clr.
   - Response: sc goes 15->0 and sc_ovf=1, staying 1 until rst_n is pulsed.
6. Async reset mid-operation
   - Stimulus: drop rst_n between clock edges with sc=7, r_flag=1.
   - Response: all outputs 0 immediately, without waiting for a clk edge.
